magnetron_sequencer: RTL
========================

MAGNETRON_SEQUENCER -- requirements
Module: magnetron_sequencer

Interface
REQ-001 Parameters SHALL be exactly these four, each given as name, default and meaning.
- TIME_W, 16: width of cook-time counter, in seconds.
- POWER_LEVELS, 10: number of duty steps per power window; must be at least 1.
- TICK_DIV, 1000: clk cycles per one-second tick; must be at least 2.
- PW, $clog2(POWER_LEVELS+1): width of power_sel.

REQ-002 The block SHALL use one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be exactly these, each given as name, direction, width and meaning.
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- startn, in, 1: start button, active-low.
- stopn, in, 1: stop/pause button, active-low.
- clearn, in, 1: clear button, active-low.
- door_closed, in, 1: high when the door is shut.
- time_load, in, TIME_W: cook time in seconds, sampled on start from IDLE.
- power_sel, in, PW: power level, sampled on start from IDLE.
- Q, out, 1: magnetron enable.
- state, out, 2: current FSM state.
- time_left, out, TIME_W: remaining seconds.
- done, out, 1: high while in DONE.

Function
REQ-004 The block SHALL register each button every cycle, and a press SHALL be a falling edge (previous sample 1, current sample 0); a held button SHALL NOT act again.
REQ-005 FSM states SHALL be IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-006 When several events occur in the same cycle, priority SHALL be clear press > door open > stop press > start press.
REQ-007 A clear press in any state SHALL go to IDLE, set time_left=0 and reset the tick and window counters.
REQ-008 IDLE + start press + door_closed + time_load!=0 SHALL go to COOK, set time_left=time_load, latch power_sel saturated to POWER_LEVELS, and zero the tick and window counters.
REQ-009 IDLE + start press with time_load=0 or door open SHALL be ignored.
REQ-010 In COOK, the tick counter SHALL count 0..TICK_DIV-1 and wrap.
- On wrap, time_left SHALL decrement by 1 and the window counter SHALL advance 0..POWER_LEVELS-1 and wrap.
- When time_left goes 1 to 0, the next state SHALL be DONE.
REQ-011 COOK + door open or stop press SHALL go to PAUSE, with the counters frozen.
REQ-012 PAUSE + start press + door_closed SHALL go to COOK, resuming the frozen counters with no reload.
REQ-013 PAUSE + stop press SHALL go to IDLE with time_left=0.
REQ-014 DONE SHALL hold done=1 and time_left=0; any start or stop press or door opening SHALL go to IDLE.
REQ-015 Q SHALL equal (state==COOK) AND (window counter < latched power) AND door_closed.
- The door_closed gating SHALL be combinational, so the interlock drops Q in the same cycle the door opens.
- Latched power = POWER_LEVELS SHALL give Q continuously on.
- Latched power = 0 SHALL give Q=0 while the timer still counts.
REQ-016 Latency: a press sampled at edge N SHALL update state at edge N+1, and Q SHALL be 1 after edge N+1 when power>0.
REQ-017 time_left SHALL never underflow, and the decrement SHALL occur only in COOK.

Reset
REQ-018 When rst=1 at a clk edge, state=IDLE, time_left=0, done=0, Q=0, all counters=0, latched power=0, and button history registers=1 (released).
REQ-019 Reset mid-COOK SHALL force Q=0 starting from the cycle after the edge, and no button edge SHALL be detected on the first post-reset cycle.

Configuration
REQ-020 Macro MAGNETRON_DONE_BEEP_EN, when defined, SHALL add output port beep (out, 1).
- beep SHALL be high for exactly TICK_DIV cycles starting at DONE entry.
- Leaving DONE early SHALL end beep.
- When the macro is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-021 Package microwave_pkg SHALL hold the state encoding constants (IDLE, COOK, PAUSE, DONE) and the 2-bit state typedef.
REQ-022 Sub-module duty_window SHALL contain the window counter and the comparison against the latched power.
- Inputs SHALL be clk, rst, tick, clr and power; output SHALL be on.
- It SHALL be parametrised by POWER_LEVELS.

Verification
All scenarios use TICK_DIV=4 and POWER_LEVELS=4.
REQ-023 Door closed, time_load=3, power_sel=4, start pulse → COOK next cycle, Q=1 for 12 cycles, then DONE with done=1 and Q=0.
REQ-024 time_load=5, power_sel=2 → within every window of 16 cycles, Q=1 for the first 8 cycles and 0 for the last 8.
REQ-025 Door opens at cycle 6 of COOK → Q=0 in the same cycle and state=PAUSE next cycle; then door closes and start is pressed → COOK resumes with the same time_left.
REQ-026 Clear, stop and door-open asserted together in COOK → IDLE with time_left=0.
REQ-027 Start with time_load=0, then start with door open, then startn held low for 20 cycles → the first two stay in IDLE, and the held press acts only once.
REQ-028 With MAGNETRON_DONE_BEEP_EN defined, reaching DONE → beep high for exactly 4 cycles; rst mid-COOK → all outputs at reset values.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types for the magnetron sequencer: FSM state encoding.
package microwave_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/duty_window.sv
// Power duty window: counts one-second ticks modulo POWER_LEVELS and
// reports whether the current second falls inside the on-portion.
module duty_window
    import microwave_pkg::*;
#(
    parameter int unsigned POWER_LEVELS = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 tick,
    input  logic                                 clr,
    input  logic [$clog2(POWER_LEVELS + 1)-1:0]  power,
    output logic                                 on
);

    localparam int unsigned LVL_W    = $clog2(POWER_LEVELS + 1);
    localparam int unsigned WIN_W    = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1;
    localparam int unsigned WIN_LAST = POWER_LEVELS - 1;
    localparam int unsigned CMP_W    = ((WIN_W > LVL_W) ? WIN_W : LVL_W) + 1;

    logic [WIN_W-1:0] win_q;

    // Window position advances once per second and wraps at POWER_LEVELS.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else if (clr) begin
            win_q <= '0;
        end else if (tick) begin
            win_q <= (win_q == WIN_W'(WIN_LAST)) ? '0 : win_q + WIN_W'(1);
        end
    end

    // On for the first 'power' seconds of each window.
    assign on = (CMP_W'(win_q) < CMP_W'(power));

endmodule

// File: rtl/magnetron_sequencer.sv
// Microwave magnetron sequencer: button edge detection, cook/pause/done
// FSM, one-second timebase, countdown and duty-cycled magnetron enable.
// Optional feature macro: MAGNETRON_DONE_BEEP_EN adds a 'beep' output that
// sounds for one second on reaching DONE.
module magnetron_sequencer
    import microwave_pkg::*;
#(
    parameter int unsigned TIME_W       = 16,
    parameter int unsigned POWER_LEVELS = 10,
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned PW           = $clog2(POWER_LEVELS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic [TIME_W-1:0] time_load,
    input  logic [PW-1:0]     power_sel,
    output logic              Q,
`ifdef MAGNETRON_DONE_BEEP_EN
    output logic              beep,
`endif
    output logic [1:0]        state,
    output logic [TIME_W-1:0] time_left,
    output logic              done
);

    localparam int unsigned TK_W      = $clog2(TICK_DIV);
    localparam int unsigned TICK_LAST = TICK_DIV - 1;
    localparam int unsigned LVL_W     = $clog2(POWER_LEVELS + 1);

    state_t            state_q;
    state_t            state_d;
    logic              start_q, start_prev;
    logic              stop_q, stop_prev;
    logic              clear_q, clear_prev;
    logic              start_press, stop_press, clear_press;
    logic [TK_W-1:0]   tick_q;
    logic [PW-1:0]     power_q;
    logic [PW-1:0]     power_sat;
    logic              load;
    logic              run;
    logic              tick;
    logic              win_clr;
    logic              win_on;

    // Button history: released (1) out of reset so nothing fires right after.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= 1'b1;
            start_prev <= 1'b1;
            stop_q     <= 1'b1;
            stop_prev  <= 1'b1;
            clear_q    <= 1'b1;
            clear_prev <= 1'b1;
        end else begin
            start_q    <= startn;
            start_prev <= start_q;
            stop_q     <= stopn;
            stop_prev  <= stop_q;
            clear_q    <= clearn;
            clear_prev <= clear_q;
        end
    end

    assign start_press = start_prev & ~start_q;
    assign stop_press  = stop_prev  & ~stop_q;
    assign clear_press = clear_prev & ~clear_q;

    assign power_sat = (32'(power_sel) > 32'(POWER_LEVELS)) ? PW'(POWER_LEVELS) : power_sel;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; priority clear > door > stop > start.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        run     = 1'b0;
        tick    = 1'b0;
        if (clear_press) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_press && door_closed && (time_load != '0)) begin
                        state_d = COOK;
                        load    = 1'b1;
                    end
                end
                COOK: begin
                    if (!door_closed || stop_press) begin
                        state_d = PAUSE;
                    end else begin
                        run = 1'b1;
                        if (tick_q == TK_W'(TICK_LAST)) begin
                            tick = 1'b1;
                            if (time_left == TIME_W'(1)) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!door_closed) begin
                        state_d = PAUSE;
                    end else if (stop_press) begin
                        state_d = IDLE;
                    end else if (start_press) begin
                        state_d = COOK;
                    end
                end
                DONE: begin
                    if (!door_closed || stop_press || start_press) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters restart on a fresh load and whenever the FSM returns to IDLE.
    assign win_clr = load || (state_d == IDLE);

    // One-second timebase; frozen outside COOK.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else if (win_clr) begin
            tick_q <= '0;
        end else if (run) begin
            tick_q <= tick ? '0 : tick_q + TK_W'(1);
        end
    end

    // Remaining time: loaded on start, decremented per second, zero in IDLE/DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_left <= '0;
        end else if ((state_d == IDLE) || (state_d == DONE)) begin
            time_left <= '0;
        end else if (load) begin
            time_left <= time_load;
        end else if (tick && (time_left != '0)) begin
            time_left <= time_left - TIME_W'(1);
        end
    end

    // Latched power level, saturated to POWER_LEVELS.
    always_ff @(posedge clk) begin
        if (rst) begin
            power_q <= '0;
        end else if (load) begin
            power_q <= power_sat;
        end
    end

    // Done flag tracks the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state_d == DONE);
        end
    end

    duty_window #(
        .POWER_LEVELS (POWER_LEVELS)
    ) u_duty_window (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clr   (win_clr),
        .power (LVL_W'(power_q)),
        .on    (win_on)
    );

    assign state = state_q;

    // Door interlock is combinational so Q drops the cycle the door opens.
    assign Q = (state_q == COOK) && win_on && door_closed;

`ifdef MAGNETRON_DONE_BEEP_EN
    logic [TK_W-1:0] beep_cnt;

    // One-second beep from DONE entry; cut short if DONE is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state_d != DONE) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state_q != DONE) begin
            beep     <= 1'b1;
            beep_cnt <= TK_W'(TICK_LAST);
        end else if (beep) begin
            if (beep_cnt == '0) begin
                beep <= 1'b0;
            end else begin
                beep_cnt <= beep_cnt - TK_W'(1);
            end
        end
    end
`endif

endmodule
